// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, a per-register pending scoreboard and a PC alias at the top address.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DW  = 32,
  parameter int AW  = 4,
  parameter int NRP = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRP*AW-1:0] ra,
  output logic [NRP*DW-1:0] rd,
  output logic [NRP-1:0]    rd_pend,
  input  logic [DW-1:0]     pc,
  input  logic              we_a,
  input  logic [AW-1:0]     wa_a,
  input  logic [DW-1:0]     wd_a,
  input  logic              we_b,
  input  logic [AW-1:0]     wa_b,
  input  logic [DW-1:0]     wd_b,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic              wconf
);

  localparam int NREG = 2**AW - 1;
  localparam logic [AW-1:0] PC_ADDR = {AW{1'b1}};

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [NREG-1:0] pend_q, pend_d;
  logic            wconf_q, wconf_d;
  logic            wr_a, wr_b;
  logic [AW-1:0]   addr;

  assign wr_a  = we_a && (wa_a != PC_ADDR);
  assign wr_b  = we_b && (wa_b != PC_ADDR);
  assign wconf = wconf_q;

  // Port A wins a collision; an issue in the same cycle as a write leaves the bit set.
  always_comb begin
    wconf_d = wconf_q | (wr_a && wr_b && (wa_a == wa_b));
    pend_d  = pend_q;
    for (int r = 0; r < NREG; r++) begin
      regs_d[r] = regs_q[r];
      if (wr_a && (wa_a == AW'(r))) begin
        regs_d[r] = wd_a;
        pend_d[r] = 1'b0;
      end else if (wr_b && (wa_b == AW'(r))) begin
        regs_d[r] = wd_b;
        pend_d[r] = 1'b0;
      end
      if (iss_en && (iss_addr == AW'(r))) pend_d[r] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q  <= '{default: '0};
      pend_q  <= '0;
      wconf_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      pend_q  <= pend_d;
      wconf_q <= wconf_d;
    end
  end

  always_comb begin
    rd      = '0;
    rd_pend = '0;
    addr    = '0;
    for (int i = 0; i < NRP; i++) begin
      addr = ra[i*AW +: AW];
      if (addr == PC_ADDR) begin
        rd[i*DW +: DW] = pc;
      end else begin
        for (int r = 0; r < NREG; r++) begin
          if (addr == AW'(r)) begin
            rd[i*DW +: DW] = regs_q[r];
            rd_pend[i]     = pend_q[r];
          end
        end
`ifdef REGFILE_BYPASS_EN
        // A forwarded value is already complete, so only a fresh issue marks it pending.
        if (wr_a && (wa_a == addr)) begin
          rd[i*DW +: DW] = wd_a;
          rd_pend[i]     = iss_en && (iss_addr == addr);
        end else if (wr_b && (wa_b == addr)) begin
          rd[i*DW +: DW] = wd_b;
          rd_pend[i]     = iss_en && (iss_addr == addr);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: expectations are queued as stimulus is applied and popped at each check point.
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int NRP = 3;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int K_RD    = 0;
  localparam int K_PEND  = 1;
  localparam int K_WCONF = 2;

  logic              clk;
  logic              rst_n;
  logic [NRP*AW-1:0] ra;
  logic [NRP*DW-1:0] rd;
  logic [NRP-1:0]    rd_pend;
  logic [DW-1:0]     pc;
  logic              we_a, we_b, iss_en;
  logic [AW-1:0]     wa_a, wa_b, iss_addr;
  logic [DW-1:0]     wd_a, wd_b;
  logic              wconf;

  typedef struct {
    string       tag;
    int          kind;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  regfile_mp #(.DW(DW), .AW(AW), .NRP(NRP)) dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .rd_pend(rd_pend), .pc(pc),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .iss_en(iss_en), .iss_addr(iss_addr), .wconf(wconf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_read(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    ra = {a2, a1, a0};
  endtask

  task automatic apply_stimulus(input logic wea, input logic [AW-1:0] waa, input logic [DW-1:0] wda,
                                input logic web, input logic [AW-1:0] wab, input logic [DW-1:0] wdb,
                                input logic iss, input logic [AW-1:0] isa);
    we_a = wea; wa_a = waa; wd_a = wda;
    we_b = web; wa_b = wab; wd_b = wdb;
    iss_en = iss; iss_addr = isa;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic exp_rd(input string tag, input int port, input logic [31:0] v);
    sb.push_back('{tag: tag, kind: K_RD, port: port, val: v});
  endtask

  task automatic exp_pend(input string tag, input int port, input logic v);
    sb.push_back('{tag: tag, kind: K_PEND, port: port, val: {31'd0, v}});
  endtask

  task automatic exp_wconf(input string tag, input logic v);
    sb.push_back('{tag: tag, kind: K_WCONF, port: 0, val: {31'd0, v}});
  endtask

  task automatic check_output();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_RD:    obs = 32'(rd >> (e.port * DW));
        K_PEND:  obs = {31'd0, rd_pend[e.port]};
        default: obs = {31'd0, wconf};
      endcase
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("[TB] FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pc    = 32'h0000_0108;
    set_read(4'h0, 4'h0, 4'h0);
    idle();
    repeat (2) tick();
    rst_n = 1'b1;

    // T1: store then asynchronous reset mid-cycle
    set_read(4'h3, 4'h5, 4'h6);
    apply_stimulus(1'b1, 4'h3, 32'hDEADBEEF, 1'b0, '0, '0, 1'b1, 4'h5);
    tick();
    idle();
    exp_rd("t1_written", 0, 32'hDEADBEEF);
    exp_pend("t1_pend_before", 1, 1'b1);
    check_output();
    #2 rst_n = 1'b0;
    exp_rd("t1_rst_rd", 0, 32'h0);
    exp_pend("t1_rst_p0", 0, 1'b0);
    exp_pend("t1_rst_p1", 1, 1'b0);
    exp_pend("t1_rst_p2", 2, 1'b0);
    exp_wconf("t1_rst_wconf", 1'b0);
    check_output();
    tick();
    rst_n = 1'b1;

    // T2: PC alias ignores writes and issues, no wconf
    set_read(4'hF, 4'hE, 4'h0);
    apply_stimulus(1'b1, 4'hF, 32'd5, 1'b1, 4'hF, 32'd9, 1'b1, 4'hF);
    exp_rd("t2_pc_pre", 0, 32'h108);
    exp_pend("t2_pend_pre", 0, 1'b0);
    check_output();
    tick();
    exp_rd("t2_pc_post", 0, 32'h108);
    exp_pend("t2_pend_post", 0, 1'b0);
    exp_wconf("t2_wconf", 1'b0);
    exp_rd("t2_r14_clean", 1, 32'h0);
    check_output();
    idle();

    // T3: dual write, then same-address collision
    set_read(4'h2, 4'h7, 4'h4);
    apply_stimulus(1'b1, 4'h2, 32'd11, 1'b1, 4'h7, 32'd22, 1'b0, '0);
    exp_rd("t3_r2_same", 0, BYP ? 32'd11 : 32'd0);
    exp_rd("t3_r7_same", 1, BYP ? 32'd22 : 32'd0);
    check_output();
    tick();
    apply_stimulus(1'b1, 4'h4, 32'd1, 1'b1, 4'h4, 32'd2, 1'b0, '0);
    exp_rd("t3_r2", 0, 32'd11);
    exp_rd("t3_r7", 1, 32'd22);
    exp_wconf("t3_wconf_pre", 1'b0);
    exp_rd("t3_coll_same", 2, BYP ? 32'd1 : 32'd0);
    check_output();
    tick();
    idle();
    exp_rd("t3_r4_a_wins", 2, 32'd1);
    exp_wconf("t3_wconf_set", 1'b1);
    check_output();
    tick();
    exp_wconf("t3_wconf_sticky", 1'b1);
    check_output();

    // T4: scoreboard set / clear / re-issue / issue+write
    set_read(4'h5, 4'h6, 4'h0);
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'h5);
    exp_pend("t4_pend_c0", 0, 1'b0);
    check_output();
    tick();
    idle();
    exp_pend("t4_pend_c1", 0, 1'b1);
    check_output();
    tick();
    tick();
    apply_stimulus(1'b1, 4'h5, 32'h77, 1'b0, '0, '0, 1'b0, '0);
    exp_pend("t4_pend_c3", 0, BYP ? 1'b0 : 1'b1);
    check_output();
    tick();
    idle();
    exp_pend("t4_pend_c4", 0, 1'b0);
    exp_rd("t4_r5_data", 0, 32'h77);
    check_output();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'h5);
    tick();
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b1, 4'h5, 32'h78, 1'b0, '0);
    exp_pend("t4_reissue", 0, BYP ? 1'b0 : 1'b1);
    check_output();
    tick();
    idle();
    exp_pend("t4_one_write_clears", 0, 1'b0);
    check_output();
    apply_stimulus(1'b0, '0, '0, 1'b1, 4'h6, 32'h66, 1'b1, 4'h6);
    exp_pend("t4_r6_same", 1, BYP ? 1'b1 : 1'b0);
    exp_rd("t4_r6_same_rd", 1, BYP ? 32'h66 : 32'h0);
    check_output();
    tick();
    idle();
    exp_pend("t4_r6_issue_wins", 1, 1'b1);
    exp_rd("t4_r6_data", 1, 32'h66);
    check_output();

    // T5: write-to-read in the same cycle
    set_read(4'h9, 4'h0, 4'h0);
    apply_stimulus(1'b1, 4'h9, 32'h55AA, 1'b0, '0, '0, 1'b0, '0);
    exp_rd("t5_same", 0, BYP ? 32'h55AA : 32'h0);
    exp_pend("t5_pend", 0, 1'b0);
    check_output();
    tick();
    idle();
    exp_rd("t5_next", 0, 32'h55AA);
    check_output();

    // T6: all ports in one cycle
    apply_stimulus(1'b1, 4'h1, 32'h1111, 1'b0, '0, '0, 1'b0, '0);
    tick();
    idle();
    pc = 32'h0000_ABCD;
    set_read(4'h1, 4'h1, 4'hF);
    exp_rd("t6_p0", 0, 32'h1111);
    exp_rd("t6_p1", 1, 32'h1111);
    exp_rd("t6_p2_pc", 2, 32'hABCD);
    exp_pend("t6_p2_pend", 2, 1'b0);
    check_output();

    // Reset clears wconf and storage
    rst_n = 1'b0;
    set_read(4'h2, 4'h6, 4'hF);
    exp_wconf("end_wconf", 1'b0);
    exp_rd("end_r2", 0, 32'h0);
    exp_pend("end_r6_pend", 1, 1'b0);
    check_output();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
